// File: rtl/dsp48_pkg.sv
// Shared widths and attribute-string constants for the DSP48E1 slice datapath.
package dsp48_pkg;
  localparam int P_WIDTH     = 48;
  localparam int CARRY_WIDTH = 4;

  localparam string SEL_PATTERN_ATTR   = "PATTERN";
  localparam string SEL_MASK_ATTR      = "MASK";
  localparam string SEL_C_INPUT        = "C";
  localparam string PATDET_ON          = "PATDET";
  localparam string PATDET_OFF         = "NO_PATDET";
  localparam string AR_NO_RESET        = "NO_RESET";
  localparam string AR_RESET_MATCH     = "RESET_MATCH";
  localparam string AR_RESET_NOT_MATCH = "RESET_NOT_MATCH";
endpackage

// File: rtl/dff.sv
// Generic register with synchronous active-high reset and clock enable; reset wins over enable.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ce) q <= d;
  end
endmodule

// File: rtl/p_output_register_pattern_detect.sv
// Pattern and inverted-pattern match of the ALU result; mask bits set to 1 are ignored.
module pattern_detect
  import dsp48_pkg::*;
(
  input  logic [P_WIDTH-1:0] alu_out,
  input  logic [P_WIDTH-1:0] pat,
  input  logic [P_WIDTH-1:0] msk,
  output logic               pd_c,
  output logic               pbd_c
);
  assign pd_c  = &((alu_out ~^ pat) | msk);
  assign pbd_c = &((alu_out ~^ ~pat) | msk);
endmodule

// File: rtl/p_output_register.sv
// P stage of the DSP48E1 slice: result/carry register, cascade outputs, pattern detect and flow flags.
// Optional macro DSP_P_AUTORESET_EN compiles in the pattern-detect driven autoreset of the P stage.
module p_output_register
  import dsp48_pkg::*;
#(
  parameter int              PREG_P               = 1,
  parameter string           USE_PATTERN_DETECT_P = "NO_PATDET",
  parameter logic [47:0]     PATTERN_P            = 48'h000000000000,
  parameter logic [47:0]     MASK_P               = 48'h3FFFFFFFFFFF,
  parameter string           SEL_PATTERN_P        = "PATTERN",
  parameter string           SEL_MASK_P           = "MASK",
  parameter string           AUTORESET_PATDET_P   = "NO_RESET"
) (
  input  logic                   clk,
  input  logic                   RSTP,
  input  logic                   CEP,
  input  logic [P_WIDTH-1:0]     alu_out,
  input  logic [CARRY_WIDTH-1:0] carry_in,
  input  logic [P_WIDTH-1:0]     C,
  output logic [P_WIDTH-1:0]     P,
  output logic [P_WIDTH-1:0]     PCOUT,
  output logic [CARRY_WIDTH-1:0] CARRYOUT,
  output logic                   CARRYCASCOUT,
  output logic                   PATTERNDETECT,
  output logic                   PATTERNBDETECT,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW
);
  localparam bit PATDET_EN = (USE_PATTERN_DETECT_P == PATDET_ON);
  localparam bit PAT_FROM_C = (SEL_PATTERN_P == SEL_C_INPUT);
  localparam bit MSK_FROM_C = (SEL_MASK_P == SEL_C_INPUT);

  logic [P_WIDTH-1:0] pat;
  logic [P_WIDTH-1:0] msk;
  logic               pd_c;
  logic               pbd_c;
  logic [1:0]         det_q;
  logic               pd_o;
  logic               pbd_o;
  logic [1:0]         past_q;
  logic               pd_past;
  logic               pbd_past;

  assign pat = PAT_FROM_C ? C : PATTERN_P;
  assign msk = MSK_FROM_C ? C : MASK_P;

  pattern_detect u_pattern_detect (
    .alu_out (alu_out),
    .pat     (pat),
    .msk     (msk),
    .pd_c    (pd_c),
    .pbd_c   (pbd_c)
  );

  generate
    if (PREG_P != 0) begin : g_preg
      logic ar;
      logic rst_p;
`ifdef DSP_P_AUTORESET_EN
      localparam bit AR_MATCH     = (AUTORESET_PATDET_P == AR_RESET_MATCH);
      localparam bit AR_NOT_MATCH = (AUTORESET_PATDET_P == AR_RESET_NOT_MATCH);
      // Autoreset only acts on an enabled edge; with CEP low it waits.
      assign ar = CEP & ((AR_MATCH & pd_o) | (AR_NOT_MATCH & pd_past & ~pd_o));
`else
      assign ar = 1'b0;
`endif
      assign rst_p = RSTP | ar;

      dff #(.WIDTH(P_WIDTH)) u_p_reg (
        .clk (clk), .rst (rst_p), .ce (CEP), .d (alu_out), .q (P)
      );
      dff #(.WIDTH(CARRY_WIDTH)) u_carry_reg (
        .clk (clk), .rst (rst_p), .ce (CEP), .d (carry_in), .q (CARRYOUT)
      );
      dff #(.WIDTH(2)) u_det_reg (
        .clk (clk), .rst (rst_p), .ce (CEP), .d ({pd_c, pbd_c}), .q (det_q)
      );
    end else begin : g_comb
      assign P        = alu_out;
      assign CARRYOUT = carry_in;
      assign det_q    = {pd_c, pbd_c};
    end
  endgenerate

  assign pd_o  = PATDET_EN & det_q[1];
  assign pbd_o = PATDET_EN & det_q[0];

  // Past copies see the gated detect outputs, so they stay 0 when detection is off.
  dff #(.WIDTH(2)) u_past_reg (
    .clk (clk), .rst (RSTP), .ce (CEP), .d ({pd_o, pbd_o}), .q (past_q)
  );
  assign pd_past  = past_q[1];
  assign pbd_past = past_q[0];

  assign PCOUT          = P;
  assign CARRYCASCOUT   = CARRYOUT[CARRY_WIDTH-1];
  assign PATTERNDETECT  = pd_o;
  assign PATTERNBDETECT = pbd_o;
  assign OVERFLOW       = pd_past & ~pd_o & ~pbd_o;
  assign UNDERFLOW      = pbd_past & ~pd_o & ~pbd_o;
endmodule

// File: tb/tb_p_output_register.sv
// Scoreboard bench for p_output_register: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_p_output_register;
`ifdef DSP_P_AUTORESET_EN
  localparam int NI = 4;
`else
  localparam int NI = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstp [NI];
  logic        cep  [NI];
  logic [47:0] alu  [NI];
  logic [3:0]  cin  [NI];
  logic [47:0] cc   [NI];
  logic [47:0] p    [NI];
  logic [47:0] pc   [NI];
  logic [3:0]  co   [NI];
  logic        cco  [NI];
  logic        pd   [NI];
  logic        pbd  [NI];
  logic        ov   [NI];
  logic        un   [NI];

  // u0: registered, static pattern 0 / default mask
  p_output_register #(.PREG_P(1), .USE_PATTERN_DETECT_P("PATDET"), .PATTERN_P(48'h0),
                      .MASK_P(48'h3FFFFFFFFFFF)) u0 (
    .clk(clk), .RSTP(rstp[0]), .CEP(cep[0]), .alu_out(alu[0]), .carry_in(cin[0]), .C(cc[0]),
    .P(p[0]), .PCOUT(pc[0]), .CARRYOUT(co[0]), .CARRYCASCOUT(cco[0]), .PATTERNDETECT(pd[0]),
    .PATTERNBDETECT(pbd[0]), .OVERFLOW(ov[0]), .UNDERFLOW(un[0]));

  // u1: pattern from C, no mask
  p_output_register #(.PREG_P(1), .USE_PATTERN_DETECT_P("PATDET"), .SEL_PATTERN_P("C"),
                      .MASK_P(48'h0)) u1 (
    .clk(clk), .RSTP(rstp[1]), .CEP(cep[1]), .alu_out(alu[1]), .carry_in(cin[1]), .C(cc[1]),
    .P(p[1]), .PCOUT(pc[1]), .CARRYOUT(co[1]), .CARRYCASCOUT(cco[1]), .PATTERNDETECT(pd[1]),
    .PATTERNBDETECT(pbd[1]), .OVERFLOW(ov[1]), .UNDERFLOW(un[1]));

  // u2: combinational P stage, detection disabled
  p_output_register #(.PREG_P(0), .USE_PATTERN_DETECT_P("NO_PATDET")) u2 (
    .clk(clk), .RSTP(rstp[2]), .CEP(cep[2]), .alu_out(alu[2]), .carry_in(cin[2]), .C(cc[2]),
    .P(p[2]), .PCOUT(pc[2]), .CARRYOUT(co[2]), .CARRYCASCOUT(cco[2]), .PATTERNDETECT(pd[2]),
    .PATTERNBDETECT(pbd[2]), .OVERFLOW(ov[2]), .UNDERFLOW(un[2]));

`ifdef DSP_P_AUTORESET_EN
  p_output_register #(.PREG_P(1), .USE_PATTERN_DETECT_P("PATDET"), .PATTERN_P(48'h64),
                      .MASK_P(48'h0), .AUTORESET_PATDET_P("RESET_MATCH")) u3 (
    .clk(clk), .RSTP(rstp[3]), .CEP(cep[3]), .alu_out(alu[3]), .carry_in(cin[3]), .C(cc[3]),
    .P(p[3]), .PCOUT(pc[3]), .CARRYOUT(co[3]), .CARRYCASCOUT(cco[3]), .PATTERNDETECT(pd[3]),
    .PATTERNBDETECT(pbd[3]), .OVERFLOW(ov[3]), .UNDERFLOW(un[3]));
`endif

  typedef struct {
    int          cyc;
    int          inst;
    string       name;
    logic [47:0] p;
    logic [3:0]  co;
    logic        pd;
    logic        pbd;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int dc, input int inst, input string name, input logic [47:0] ep,
                           input logic [3:0] eco, input logic epd, input logic epbd,
                           input logic eov, input logic eun);
    exp_t e;
    e.cyc = cyc + dc; e.inst = inst; e.name = name; e.p = ep; e.co = eco;
    e.pd = epd; e.pbd = epbd; e.ov = eov; e.un = eun;
    sb.push_back(e);
  endtask

  task automatic drive(input int k, input logic r, input logic ce, input logic [47:0] a,
                       input logic [3:0] ci);
    rstp[k] = r; cep[k] = ce; alu[k] = a; cin[k] = ci;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input exp_t e);
    int k;
    k = e.inst;
    n_cmp++;
    if (p[k] !== e.p || pc[k] !== e.p || co[k] !== e.co || cco[k] !== e.co[3] ||
        pd[k] !== e.pd || pbd[k] !== e.pbd || ov[k] !== e.ov || un[k] !== e.un) begin
      n_bad++;
      $display("FAIL %s inst%0d: got P=%h PCOUT=%h CO=%h CCO=%b PD=%b PBD=%b OV=%b UN=%b, required P=%h CO=%h CCO=%b PD=%b PBD=%b OV=%b UN=%b",
               e.name, k, p[k], pc[k], co[k], cco[k], pd[k], pbd[k], ov[k], un[k],
               e.p, e.co, e.co[3], e.pd, e.pbd, e.ov, e.un);
    end
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL %s inst%0d: expectation for cycle %0d missed, now cycle %0d",
                 sb[i].name, sb[i].inst, sb[i].cyc, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      rstp[k] = 1'b1; cep[k] = 1'b0; alu[k] = '0; cin[k] = '0; cc[k] = '0;
    end
    tick();
    tick();
    expect_at(0, 0, "reset_u0", 48'h0, 4'h0, 0, 0, 0, 0);
    expect_at(0, 1, "reset_u1", 48'h0, 4'h0, 0, 0, 0, 0);
`ifdef DSP_P_AUTORESET_EN
    expect_at(0, 3, "reset_u3", 48'h0, 4'h0, 0, 0, 0, 0);
`endif
    for (int k = 0; k < NI; k++) rstp[k] = 1'b0;

    // capture, hold, reset-over-enable
    tick(); drive(0, 0, 1, 48'h123456789ABC, 4'hA);
    expect_at(1, 0, "t1_capture", 48'h123456789ABC, 4'hA, 1, 0, 0, 0);
    tick(); drive(0, 0, 0, 48'hFFFFFFFFFFFF, 4'h5);
    expect_at(1, 0, "t1_hold", 48'h123456789ABC, 4'hA, 1, 0, 0, 0);
    tick(); drive(0, 1, 1, 48'hFFFFFFFFFFFF, 4'hF);
    expect_at(1, 0, "t2_reset", 48'h0, 4'h0, 0, 0, 0, 0);

    // detect, overflow, underflow
    tick(); drive(0, 0, 1, 48'h000000000005, 4'h0);
    expect_at(1, 0, "t3_pd", 48'h000000000005, 4'h0, 1, 0, 0, 0);
    tick(); drive(0, 0, 1, 48'hC00000000000, 4'h0);
    expect_at(1, 0, "t3_pbd", 48'hC00000000000, 4'h0, 0, 1, 0, 0);
    tick(); drive(0, 0, 1, 48'h000000000001, 4'h0);
    expect_at(1, 0, "t4_pre_ovf", 48'h000000000001, 4'h0, 1, 0, 0, 0);
    tick(); drive(0, 0, 1, 48'h400000000000, 4'h0);
    expect_at(1, 0, "t4_ovf", 48'h400000000000, 4'h0, 0, 0, 1, 0);
    tick(); drive(0, 0, 1, 48'h400000000001, 4'h0);
    expect_at(1, 0, "t4_ovf_clear", 48'h400000000001, 4'h0, 0, 0, 0, 0);
    tick(); drive(0, 0, 1, 48'hFFFFFFFFFFFF, 4'h0);
    expect_at(1, 0, "t4_pre_unf", 48'hFFFFFFFFFFFF, 4'h0, 0, 1, 0, 0);
    tick(); drive(0, 0, 1, 48'hBFFFFFFFFFFF, 4'h0);
    expect_at(1, 0, "t4_unf", 48'hBFFFFFFFFFFF, 4'h0, 0, 0, 0, 1);
    tick(); drive(0, 0, 0, 48'h000000000000, 4'h0);
    expect_at(1, 0, "t4_unf_hold", 48'hBFFFFFFFFFFF, 4'h0, 0, 0, 0, 1);
    tick(); drive(0, 0, 1, 48'hBFFFFFFFFFFF, 4'h0);
    expect_at(1, 0, "t4_unf_clear", 48'hBFFFFFFFFFFF, 4'h0, 0, 0, 0, 0);

    // dynamic pattern from C
    tick(); cc[1] = 48'h00000000FFFF; drive(1, 0, 1, 48'h00000000FFFF, 4'h0);
    expect_at(1, 1, "t5_c_match", 48'h00000000FFFF, 4'h0, 1, 0, 0, 0);
    tick(); drive(1, 0, 1, 48'h00000000FFFE, 4'h0);
    expect_at(1, 1, "t5_c_nomatch", 48'h00000000FFFE, 4'h0, 0, 0, 1, 0);

    // combinational P stage, zero latency, detect tied low
    tick(); drive(2, 0, 1, 48'hDEADBEEF0123, 4'h9);
    expect_at(0, 2, "comb_pass", 48'hDEADBEEF0123, 4'h9, 0, 0, 0, 0);
    tick(); drive(2, 0, 0, 48'h000000000000, 4'h3);
    expect_at(0, 2, "comb_nopatdet", 48'h000000000000, 4'h3, 0, 0, 0, 0);
    tick(); drive(2, 0, 1, 48'hC00000000000, 4'h8);
    expect_at(0, 2, "comb_nopatdet_b", 48'hC00000000000, 4'h8, 0, 0, 0, 0);

`ifdef DSP_P_AUTORESET_EN
    tick(); drive(3, 0, 1, 48'd50, 4'h7);
    expect_at(1, 3, "t6_acc50", 48'd50, 4'h7, 0, 0, 0, 0);
    tick(); drive(3, 0, 1, 48'd100, 4'h7);
    expect_at(1, 3, "t6_acc100", 48'd100, 4'h7, 1, 0, 0, 0);
    tick(); drive(3, 0, 0, 48'd150, 4'h7);
    expect_at(1, 3, "t6_deferred", 48'd100, 4'h7, 1, 0, 0, 0);
    tick(); drive(3, 0, 1, 48'd150, 4'h7);
    expect_at(1, 3, "t6_autoreset", 48'd0, 4'h0, 0, 0, 1, 0);
    tick(); drive(3, 0, 1, 48'd150, 4'h7);
    expect_at(1, 3, "t6_resume", 48'd150, 4'h7, 0, 0, 0, 0);
`endif

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    while (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s inst%0d: expectation never checked", sb[0].name, sb[0].inst);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/p_output_register.md
Name: p_output_register

Overview:
- Output end of the DSP48E1 slice datapath, the counterpart to the dual A/B input registers.
- Captures the 48-bit ALU result and carry-out into the P stage.
- Drives P and the PCOUT/CARRYCASCOUT cascade to the next slice's PCIN/CARRYCASCIN.
- Generates pattern detect, pattern-bar detect, their one-cycle-past copies, and overflow/underflow flags.

Parameters:
- PREG_P, 1: 1 = P stage registered; 0 = P, CARRYOUT and the detect outputs are combinational from the inputs.
- USE_PATTERN_DETECT_P, "NO_PATDET": "PATDET" enables the detect logic. With "NO_PATDET", all detect and flow outputs are held at 0.
- PATTERN_P, 48'h000000000000: static pattern.
- MASK_P, 48'h3FFFFFFFFFFF: static mask; a mask bit of 1 means ignore that bit.
- SEL_PATTERN_P, "PATTERN": "PATTERN" uses PATTERN_P; "C" uses the C input.
- SEL_MASK_P, "MASK": "MASK" uses MASK_P; "C" uses the C input.
- AUTORESET_PATDET_P, "NO_RESET": "NO_RESET", "RESET_MATCH" or "RESET_NOT_MATCH". Used only when the optional feature is compiled in.

Ports:
- clk, input, 1: clock.
- RSTP, input, 1: synchronous, active-high reset of every register in the block.
- CEP, input, 1: clock enable for all P-stage registers.
- alu_out, input, 48: ALU result.
- carry_in, input, 4: ALU CARRYOUT[3:0].
- C, input, 48: dynamic pattern/mask source.
- P, output, 48: result.
- PCOUT, output, 48: cascade out; always equal to P.
- CARRYOUT, output, 4: carry out.
- CARRYCASCOUT, output, 1: equals CARRYOUT[3].
- PATTERNDETECT, output, 1: pattern matched.
- PATTERNBDETECT, output, 1: inverted pattern matched.
- OVERFLOW, output, 1: overflow flag.
- UNDERFLOW, output, 1: underflow flag.

Behaviour:
- Reset and clocking:
  - One clock (clk); reset RSTP is synchronous, active-high.
  - On RSTP=1 at a clk edge, all P-stage and past registers clear to 0. Therefore P, PCOUT, CARRYOUT, CARRYCASCOUT, PATTERNDETECT, PATTERNBDETECT, OVERFLOW and UNDERFLOW all read 0.
  - RSTP takes priority over CEP and over autoreset.
- Detect equations (combinational on alu_out):
  - pd_c = &((alu_out ~^ pat) | msk)
  - pbd_c = &((alu_out ~^ ~pat) | msk)
  - pat and msk are chosen by SEL_PATTERN_P and SEL_MASK_P.
- PREG_P=1:
  - On CEP=1, P<=alu_out, CARRYOUT<=carry_in, PATTERNDETECT<=pd_c, PATTERNBDETECT<=pbd_c. Latency is 1 cycle.
  - With CEP=0, all registers hold.
- PREG_P=0: P, CARRYOUT, PATTERNDETECT and PATTERNBDETECT pass through combinationally with 0 latency.
- Past registers (both PREG_P settings): on a CEP=1 edge, pd_past<=PATTERNDETECT and pbd_past<=PATTERNBDETECT.
- Flow flags (combinational):
  - OVERFLOW = pd_past & ~PATTERNDETECT & ~PATTERNBDETECT.
  - UNDERFLOW = pbd_past & ~PATTERNDETECT & ~PATTERNBDETECT.
- USE_PATTERN_DETECT_P="NO_PATDET": the four detect/flow outputs are tied to 0, and the past registers stay 0.
- No state machine; the sequential state is the P, carry, detect and past registers.
- Simultaneous events:
  - RSTP with CEP: reset wins.
  - Autoreset with CEP=0: no action; autoreset waits for CEP.

Optional Feature:
- Macro: DSP_P_AUTORESET_EN.
- Defined: autoreset logic is compiled in. On a clk edge with CEP=1 and RSTP=0, the P, CARRYOUT and detect registers clear as if RSTP were asserted when either:
  - AUTORESET_PATDET_P="RESET_MATCH" and PATTERNDETECT=1, or
  - AUTORESET_PATDET_P="RESET_NOT_MATCH" and pd_past=1 and PATTERNDETECT=0.
- Past registers still capture normally on that edge.
- Undefined: no autoreset logic exists, and AUTORESET_PATDET_P is ignored.

Decomposition:
- Shared package dsp48_pkg holds:
  - P_WIDTH=48 and CARRY_WIDTH=4.
  - The selector string constants for SEL_PATTERN/SEL_MASK and AUTORESET modes.
- Sub-module pattern_detect: combinational pd_c/pbd_c from alu_out, pat and msk.
- Registers reuse the existing dff module (rst, ce). The reset input is driven by RSTP | autoreset.

Test Plan:
1. PREG_P=1, CEP=1, alu_out=48'h123456789ABC, carry_in=4'hA → next cycle P=PCOUT=48'h123456789ABC, CARRYOUT=4'hA, CARRYCASCOUT=1. With CEP=0 and new inputs, values hold.
2. RSTP=1 together with CEP=1 and alu_out=48'hFFFFFFFFFFFF → next cycle every output is 0.
3. PATDET, PATTERN_P=0, MASK_P=48'h3FFFFFFFFFFF: alu_out=48'h000000000005 → PATTERNDETECT=1. Then alu_out=48'hC00000000000 → PATTERNBDETECT=1.
4. PATDET, same pattern/mask: sequence alu_out=48'h1, 48'h400000000000, 48'h400000000001 → OVERFLOW=1 in the cycle P=48'h400000000000, 0 otherwise. Mirrored sequence 48'hFFFFFFFFFFFF, 48'hBFFFFFFFFFFF → UNDERFLOW=1.
5. SEL_PATTERN_P="C", C=48'h00000000FFFF, MASK_P=0: alu_out=48'h00000000FFFF → PATTERNDETECT=1; alu_out=48'h00000000FFFE → PATTERNDETECT=0.
6. DSP_P_AUTORESET_EN defined, RESET_MATCH, PATTERN_P=48'h64, MASK_P=0, accumulating alu_out 100 → P=100 with PATTERNDETECT=1. The following CEP edge clears P to 0. With CEP=0, the clear is deferred.
